relu_maxpool2_s2: RTL

RELU_MAXPOOL2_S2 -- requirements
Module: relu_maxpool2_s2

---
 rtl/relu_maxpool2_s2.sv | 117 +++++++++++
 1 files changed

// File: rtl/relu_maxpool2_s2.sv
// ReLU + saturate followed by 2x2 stride-2 pooling over a raster-order feature map.
// Max pooling by default; define POOL_AVG_EN to switch to truncated 2x2 averaging.
module relu_maxpool2_s2 #(
    parameter int DW_IN      = 32,
    parameter int DW         = 8,
    parameter int SHIFT      = 0,
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [DW_IN-1:0] data_i,
    input  logic                    valid_i,
    output logic signed [DW-1:0]    data_o,
    output logic                    valid_o,
    output logic                    frame_done_o
);

    localparam int CW       = 8;
    localparam int LB_DEPTH = IMG_Width / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam bit W_ODD    = (IMG_Width % 2) == 1;
    localparam bit H_ODD    = (IMG_Height % 2) == 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_Height - 1);
    localparam logic [CW-1:0] ROW_PRE  = CW'(IMG_Height - 2);
    localparam logic signed [DW_IN-1:0] QMAX = DW_IN'((1 << (DW - 1)) - 1);
`ifdef POOL_AVG_EN
    localparam int LW = DW + 1;
`else
    localparam int LW = DW;
`endif

    typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, ROW_DROP} state_t;

    state_t                  state;
    logic [CW-1:0]           col, row;
    logic [DW-1:0]           hold;
    logic [DW-1:0]           q;
    logic signed [DW_IN-1:0] shifted;
    logic [LB_AW-1:0]        lb_idx;
    logic [LW-1:0]           pair;
    logic [DW-1:0]           win;
    // Rounded up to a power of two so a single-entry buffer still has a legal index.
    logic [LW-1:0]           lb [2**LB_AW];

    assign shifted = data_i >>> SHIFT;
    assign lb_idx  = col[LB_AW:1];

    always_comb begin
        q = shifted[DW-1:0];
        if (shifted[DW_IN-1])
            q = '0;
        else if (shifted > QMAX)
            q = DW'(QMAX);
    end

`ifdef POOL_AVG_EN
    logic [DW+1:0] sum4;
    always_comb begin
        pair = LW'(hold) + LW'(q);
        sum4 = (DW+2)'(lb[lb_idx]) + (DW+2)'(hold) + (DW+2)'(q);
        win  = DW'(sum4 >> 2);
    end
`else
    always_comb begin
        pair = (q > hold) ? q : hold;
        win  = (lb[lb_idx] > pair) ? lb[lb_idx] : pair;
    end
`endif

    always_ff @(posedge clk) begin
        if (valid_i && state == ROW_EVEN && col[0])
            lb[lb_idx] <= pair;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ROW_EVEN;
            col          <= '0;
            row          <= '0;
            hold         <= '0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            if (valid_i) begin
                // The trailing column of an odd-width row has no partner and is dropped.
                if (!col[0] && !(W_ODD && col == COL_LAST))
                    hold <= q;
                if (col[0] && state == ROW_ODD) begin
                    data_o  <= $signed(win);
                    valid_o <= 1'b1;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    case (state)
                        ROW_EVEN: state <= ROW_ODD;
                        ROW_ODD:  state <= (H_ODD && row == ROW_PRE) ? ROW_DROP : ROW_EVEN;
                        default:  state <= ROW_EVEN;
                    endcase
                    if (row == ROW_LAST) begin
                        row          <= '0;
                        frame_done_o <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
